// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared segment patterns and digit index type for the scanner
package seg_pkg;

  typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} digit_t;

  // Active-low cathode patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] AN_OFF    = 4'b1111;

endpackage

// File: rtl/hex_to_seg.sv
// rtl/hex_to_seg.sv - combinational nibble to 7-segment decoder
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_display_scanner.sv
// rtl/seg_display_scanner.sv - 4-digit multiplexed hex display scanner with frame shadowing
module seg_display_scanner
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = 100_000,
  parameter int BLANK_CYC   = 1_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] value,
  input  logic        lower_bytes,
  input  logic        blank_lz,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  if (REFRESH_DIV <= BLANK_CYC || BLANK_CYC < 1) begin : g_bad_params
    $error("seg_display_scanner: need REFRESH_DIV > BLANK_CYC >= 1");
  end

  logic [CW-1:0] cnt;
  logic          tick;
  digit_t        digit;
  digit_t        digit_next;
  logic [15:0]   shadow;
  logic [3:0]    nibble;
  logic [6:0]    dec_seg;
  logic          digit_blank;
  logic          blank_phase;
  logic [3:0]    an_next;
  logic [6:0]    seg_next;

  assign tick        = (cnt == CW'(REFRESH_DIV - 1));
  assign blank_phase = (cnt < CW'(BLANK_CYC));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit <= DIG0;
    end else begin
      digit <= digit_next;
    end
  end

  always_comb begin
    digit_next = digit;
    if (tick) begin
      case (digit)
        DIG0:    digit_next = DIG1;
        DIG1:    digit_next = DIG2;
        DIG2:    digit_next = DIG3;
        DIG3:    digit_next = DIG0;
        default: digit_next = DIG0;
      endcase
    end
  end

  // Latched only at the frame boundary so all four digits come from one word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow <= 16'h0000;
    end else if (tick && digit == DIG3) begin
      shadow <= lower_bytes ? value[15:0] : value[31:16];
    end
  end

  always_comb begin
    nibble      = shadow[3:0];
    digit_blank = 1'b0;
    case (digit)
      DIG0: nibble = shadow[3:0];
      DIG1: begin
        nibble      = shadow[7:4];
        digit_blank = blank_lz && (shadow[15:4] == 12'h000);
      end
      DIG2: begin
        nibble      = shadow[11:8];
        digit_blank = blank_lz && (shadow[15:8] == 8'h00);
      end
      DIG3: begin
        nibble      = shadow[15:12];
        digit_blank = blank_lz && (shadow[15:12] == 4'h0);
      end
      default: nibble = shadow[3:0];
    endcase
  end

  hex_to_seg u_hex_to_seg (
    .nibble (nibble),
    .seg    (dec_seg)
  );

  always_comb begin
    an_next  = AN_OFF;
    seg_next = SEG_BLANK;
    if (!blank_phase) begin
      an_next = ~(4'b0001 << digit);
      if (!digit_blank) begin
        seg_next = dec_seg;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an  <= AN_OFF;
      seg <= SEG_BLANK;
    end else begin
      an  <= an_next;
      seg <= seg_next;
    end
  end

endmodule

// File: doc/seg_display_scanner.md
SEG_DISPLAY_SCANNER -- requirements
Module: seg_display_scanner

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100_000, clk cycles per digit slot (1 kHz/digit at 100 MHz).
REQ-002 SHALL have parameter BLANK_CYC, default 1_000, cycles at slot start with all anodes off (anti-ghosting).
REQ-003 SHALL have port clk  input  1  system clock; single clock domain.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port value  input  32  word to display, e.g. PC, instruction or ALU result.
REQ-006 SHALL have port lower_bytes  input  1  1 = show value[15:0], 0 = show value[31:16].
REQ-007 SHALL have port blank_lz  input  1  1 = suppress leading zero digits.
REQ-008 SHALL have port seg  output  7  active-low cathodes, bit order {g,f,e,d,c,b,a}.
REQ-009 SHALL have port an  output  4  active-low anodes; an[0] is the rightmost digit.

Function
REQ-010 SHALL run slot counter 0..REFRESH_DIV-1, wrapping to 0; tick = counter at REFRESH_DIV-1.
REQ-011 SHALL step digit index DIG0->DIG1->DIG2->DIG3->DIG0, one step per tick, no other transitions.
REQ-012 SHALL load shadow register on the tick in which digit goes DIG3->DIG0: lower_bytes ? value[15:0] : value[31:16].
REQ-013 SHALL hold shadow between loads; value/lower_bytes changes mid-scan never tear a frame.
REQ-014 SHALL display shadow nibble [4k+3:4k] in DIGk.
REQ-015 SHALL drive an = all 1s while slot counter < BLANK_CYC, else one-hot-low on current digit.
REQ-016 SHALL drive seg = 7'b1111111 whenever an is all 1s or current digit is blanked.
REQ-017 SHALL blank DIGk (k>=1) when blank_lz=1 and nibbles k..3 of shadow are all zero; DIG0 never blanked.
REQ-018 SHALL decode hex, e.g. 0->1000000, 1->1111001, 8->0000000, A->0001000, F->0001110.
REQ-019 SHALL register seg and an; they reflect counter/digit state with exactly 1 cycle latency.
REQ-020 SHALL sample blank_lz combinationally per slot (no shadowing).
REQ-021 SHALL reject REFRESH_DIV <= BLANK_CYC or BLANK_CYC < 1 at elaboration.

Reset
REQ-022 SHALL on reset assertion immediately force counter=0, digit=DIG0, shadow=16'h0000, an=4'b1111, seg=7'b1111111.
REQ-023 SHALL, after reset deassertion, begin a DIG0 slot with blanking interval first; first shadow load after 4*REFRESH_DIV cycles.
REQ-024 SHALL treat reset mid-scan identically to power-up reset; no partial state retained.

Structure
REQ-025 SHALL place segment encoding constants (16 hex patterns, SEG_BLANK) and digit-index enum in shared package seg_pkg.
REQ-026 SHALL implement nibble-to-segment decode in combinational sub-module hex_to_seg (4-bit in, 7-bit out).
REQ-027 SHALL keep counter, digit FSM, shadow and output registers in seg_display_scanner; expected size 120-250 RTL lines.

Verification (REFRESH_DIV=8, BLANK_CYC=2)
REQ-028 SHALL check reset: pulse reset mid-slot -> same cycle an=1111, seg=1111111; next DIG0 slot shows an=1111 for cycles 1-2 (1-cycle lag), then 1110.
REQ-029 SHALL check scan: value=32'h0000_1234, lower_bytes=1, blank_lz=0, run 2 frames -> second frame DIG0..DIG3 seg = 4,3,2,1 patterns, an 1110,1101,1011,0111.
REQ-030 SHALL check halfword select: value=32'hABCD_0000, lower_bytes=0 -> after next frame boundary digits show D,C,B,A; lower_bytes=1 -> 0,0,0,0.
REQ-031 SHALL check tear-free: change value from 32'h1111 to 32'h2222 during DIG1 -> DIG2, DIG3 still show 1; next frame all 2.
REQ-032 SHALL check leading-zero blanking: shadow 16'h0050, blank_lz=1 -> DIG3, DIG2 seg=1111111, DIG1=5, DIG0=0; shadow 0000 -> only DIG0 lit showing 0.
REQ-033 SHALL check wrap: counter sequence 0..7,0 and digit 3->0 transition coincide with shadow load over 100 frames (assertion).
